// File: rtl/regfile_wb_ctrl.sv
// Register file write-port controller: round-robin arbitration between ALU (A) and
// load/IO (B) writebacks, registered write port, and a busy-bit scoreboard.
module regfile_wb_ctrl #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ack,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ack,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_addr,
    input  logic [AW-1:0] s_addr,
    input  logic [AW-1:0] t_addr,
    output logic          s_busy,
    output logic          t_busy,
    output logic [DW-1:0] D,
    output logic          D_En,
    output logic [AW-1:0] D_Addr
);
    localparam int NREG = 1 << AW;

    logic            ptr_q, ptr_d;
    logic [DW-1:0]   d_q, d_d;
    logic            en_q, en_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            gnt_any;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;

    // ptr selects the winner only when both request; acks are gated off during reset
    assign a_ack = !reset && a_req && (!b_req || !ptr_q);
    assign b_ack = !reset && b_req && (!a_req || ptr_q);

    always_comb begin
        gnt_any  = a_ack | b_ack;
        gnt_addr = a_ack ? a_addr : b_addr;
        gnt_data = a_ack ? a_data : b_data;

        ptr_d = ptr_q;
        if (a_ack) begin
            ptr_d = 1'b1;
        end else if (b_ack) begin
            ptr_d = 1'b0;
        end

        // R0 writes are accepted but never reach the file
        en_d   = gnt_any && (gnt_addr != '0);
        d_d    = gnt_any ? gnt_data : d_q;
        addr_d = gnt_any ? gnt_addr : addr_q;

        // Clear first so a same-edge reservation of the same register wins
        busy_d = busy_q;
        if (en_q) begin
            busy_d[addr_q] = 1'b0;
        end
        if (rsv_en && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= 1'b0;
            d_q    <= '0;
            en_q   <= 1'b0;
            addr_q <= '0;
            busy_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            d_q    <= d_d;
            en_q   <= en_d;
            addr_q <= addr_d;
            busy_q <= busy_d;
        end
    end

    assign s_busy = (s_addr != '0) && busy_q[s_addr];
    assign t_busy = (t_addr != '0) && busy_q[t_addr];

    assign D      = d_q;
    assign D_En   = en_q;
    assign D_Addr = addr_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed and randomized bench for regfile_wb_ctrl against a behavioural model of
// the arbitration, write port and scoreboard rules.
module tb_regfile_wb_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, b_req, rsv_en;
    logic [AW-1:0] a_addr, b_addr, rsv_addr, s_addr, t_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_ack, b_ack, s_busy, t_busy, D_En;
    logic [DW-1:0] D;
    logic [AW-1:0] D_Addr;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    bit          m_turn_b;
    bit          m_busy [32];
    bit          m_en;
    int          m_addr;
    logic [31:0] m_data;
    logic        obs_a, obs_b;
    bit          a_pend, b_pend;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .s_addr(s_addr), .t_addr(t_addr), .s_busy(s_busy), .t_busy(t_busy),
        .D(D), .D_En(D_En), .D_Addr(D_Addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_turn_b = 1'b0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_en   = 1'b0;
        m_addr = 0;
        m_data = '0;
    endtask

    // Called one step after a rising edge with inputs already driven for this cycle.
    task automatic do_cycle(input string tag);
        bit          exp_a, exp_b;
        int          ga;
        logic [31:0] gd;
        bit          r_en;
        int          r_addr;
        #1;
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (a_req && b_req) begin
            if (m_turn_b) exp_b = 1'b1;
            else          exp_a = 1'b1;
        end else if (a_req) begin
            exp_a = 1'b1;
        end else if (b_req) begin
            exp_b = 1'b1;
        end
        obs_a = a_ack;
        obs_b = b_ack;
        chk({tag, ".a_ack"}, 32'(a_ack), 32'(exp_a));
        chk({tag, ".b_ack"}, 32'(b_ack), 32'(exp_b));
        chk({tag, ".s_busy"}, 32'(s_busy), 32'((s_addr != 0) && m_busy[s_addr]));
        chk({tag, ".t_busy"}, 32'(t_busy), 32'((t_addr != 0) && m_busy[t_addr]));
        ga     = exp_a ? int'(a_addr) : int'(b_addr);
        gd     = exp_a ? a_data : b_data;
        r_en   = rsv_en;
        r_addr = int'(rsv_addr);
        @(posedge clk);
        #1;
        if (m_en) m_busy[m_addr] = 1'b0;
        if (r_en && r_addr != 0) m_busy[r_addr] = 1'b1;
        if (exp_a || exp_b) begin
            m_en     = (ga != 0);
            m_addr   = ga;
            m_data   = gd;
            m_turn_b = exp_a;
        end else begin
            m_en = 1'b0;
        end
        chk({tag, ".D_En"}, 32'(D_En), 32'(m_en));
        chk({tag, ".D"}, D, m_data);
        chk({tag, ".D_Addr"}, 32'(D_Addr), 32'(m_addr));
    endtask

    initial begin
        reset = 1'b1;
        a_req = 0; b_req = 0; rsv_en = 0;
        a_addr = '0; b_addr = '0; rsv_addr = '0; s_addr = '0; t_addr = '0;
        a_data = '0; b_data = '0;
        a_pend = 0; b_pend = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.D_En", 32'(D_En), 32'd0);
        chk("rst.D", D, 32'd0);
        reset = 1'b0;

        // Traffic in flight, then reset asserted mid-cycle
        a_req = 1; a_addr = 5'd4; a_data = 32'h44; rsv_en = 1; rsv_addr = 5'd6;
        s_addr = 5'd6; t_addr = 5'd4;
        do_cycle("pre");
        rsv_en = 0;
        chk("pre.s_busy_set", 32'(s_busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst.a_ack", 32'(a_ack), 32'd0);
        chk("rst.D_En_mid", 32'(D_En), 32'd0);
        chk("rst.D_mid", D, 32'd0);
        chk("rst.D_Addr_mid", 32'(D_Addr), 32'd0);
        chk("rst.s_busy", 32'(s_busy), 32'd0);
        a_req = 0;
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rel.D_En", 32'(D_En), 32'd0);
        chk("rel.D", D, 32'd0);
        chk("rel.D_Addr", 32'(D_Addr), 32'd0);
        chk("rel.a_ack", 32'(a_ack), 32'd0);
        chk("rel.s_busy", 32'(s_busy), 32'd0);
        chk("rel.t_busy", 32'(t_busy), 32'd0);

        // Round-robin contention: A, B, A, B
        a_req = 1; a_addr = 5'd3; a_data = 32'h11111111;
        b_req = 1; b_addr = 5'd7; b_data = 32'h22222222;
        for (int i = 0; i < 4; i++) begin
            do_cycle("rr");
            chk("rr.order", 32'(obs_a), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr.one_ack", 32'(obs_a) + 32'(obs_b), 32'd1);
            chk("rr.D_Addr_seq", 32'(D_Addr), (i % 2 == 0) ? 32'd3 : 32'd7);
        end

        // Single requester B
        a_req = 0; b_addr = 5'd9; b_data = 32'hDEADBEEF;
        do_cycle("single");
        chk("single.b_ack", 32'(obs_b), 32'd1);
        chk("single.D_En", 32'(D_En), 32'd1);
        chk("single.D_Addr", 32'(D_Addr), 32'd9);
        chk("single.D", D, 32'hDEADBEEF);
        a_req = 1; a_addr = 5'd1; a_data = 32'hA1; b_addr = 5'd2; b_data = 32'hB2;
        do_cycle("ptr0");
        chk("ptr0.a_wins", 32'(obs_a), 32'd1);
        a_req = 0;
        do_cycle("bhold");
        chk("bhold.b_ack", 32'(obs_b), 32'd1);
        b_req = 0;
        do_cycle("idle");
        chk("idle.D_En", 32'(D_En), 32'd0);
        chk("idle.D_hold", D, 32'hB2);
        chk("idle.D_Addr_hold", 32'(D_Addr), 32'd2);

        // R0 write
        a_req = 1; a_addr = 5'd0; a_data = 32'hFFFFFFFF;
        do_cycle("r0");
        chk("r0.a_ack", 32'(obs_a), 32'd1);
        chk("r0.D_En", 32'(D_En), 32'd0);
        a_addr = 5'd1; a_data = 32'hA1; b_req = 1; b_addr = 5'd2; b_data = 32'hB2;
        do_cycle("ptr1");
        chk("ptr1.b_wins", 32'(obs_b), 32'd1);
        b_req = 0;
        do_cycle("ahold");
        chk("ahold.a_ack", 32'(obs_a), 32'd1);

        // Scoreboard lifecycle on register 5
        a_req = 0; rsv_en = 1; rsv_addr = 5'd5; s_addr = 5'd5; t_addr = 5'd0;
        do_cycle("sb.rsv");
        chk("sb.busy_set", 32'(s_busy), 32'd1);
        rsv_addr = 5'd0;
        do_cycle("sb.rsv0");
        chk("sb.t_busy_r0", 32'(t_busy), 32'd0);
        rsv_en = 0;
        do_cycle("sb.hold");
        chk("sb.busy_hold", 32'(s_busy), 32'd1);
        a_req = 1; a_addr = 5'd5; a_data = 32'h55;
        do_cycle("sb.wr");
        chk("sb.busy_n1", 32'(s_busy), 32'd1);
        a_req = 0;
        do_cycle("sb.wb");
        chk("sb.busy_n2", 32'(s_busy), 32'd0);

        // Set/clear collision on register 5
        rsv_en = 1; rsv_addr = 5'd5;
        do_cycle("col.rsv");
        rsv_en = 0; a_req = 1; a_addr = 5'd5; a_data = 32'h56;
        do_cycle("col.wr");
        a_req = 0; rsv_en = 1; rsv_addr = 5'd5;
        do_cycle("col.both");
        chk("col.busy_kept", 32'(s_busy), 32'd1);
        rsv_en = 0;
        do_cycle("col.after");
        chk("col.busy_still", 32'(s_busy), 32'd1);

        // Randomized traffic obeying the hold-until-ack handshake
        for (int i = 0; i < 400; i++) begin
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend = 1; a_addr = 5'($urandom_range(0, 31)); a_data = $urandom;
            end
            if (!b_pend && $urandom_range(0, 2) != 0) begin
                b_pend = 1; b_addr = 5'($urandom_range(0, 31)); b_data = $urandom;
            end
            a_req    = a_pend;
            b_req    = b_pend;
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 31));
            s_addr   = 5'($urandom_range(0, 31));
            t_addr   = 5'($urandom_range(0, 31));
            do_cycle("rnd");
            if (obs_a === 1'b1) a_pend = 0;
            if (obs_b === 1'b1) b_pend = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-port controller and pending-write scoreboard for the 32 x 32-bit register file. Two writeback sources share the register file's single write port: requester A is the ALU writeback and requester B is the load/IO writeback. A round-robin arbiter selects between them, and the chosen write is registered onto the file's D/D_En/D_Addr inputs. A busy-bit scoreboard tracks destinations with a write still outstanding, so issue logic can hold instructions that read those registers.

## Interface
- DW, 32, data width
- AW, 5, register address width (2^AW registers)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- a_req  in  1  requester A has a write pending
- a_addr  in  AW  requester A destination
- a_data  in  DW  requester A write data
- a_ack  out  1  A's write accepted this cycle (combinational)
- b_req, b_addr, b_data, b_ack: same meaning for requester B
- rsv_en  in  1  reserve a destination (mark busy) at issue
- rsv_addr  in  AW  destination to reserve
- s_addr, t_addr  in  AW  source addresses being checked
- s_busy, t_busy  out  1  source has an outstanding write (combinational)
- D  out  DW  register file write data (registered)
- D_En  out  1  register file write enable (registered)
- D_Addr  out  AW  register file write address (registered)

## Operation
- **Handshake:** valid/ready. A transfer occurs on a rising edge where req && ack are both high.
  - A requester holds req, addr and data stable until it sees ack.
  - It may present its next item in the cycle after ack.
- **Arbitration:**
  - One priority register, ptr. ptr=0 means A has priority; ptr=1 means B has priority.
  - If both requesters are asserting req, grant the one ptr selects.
  - If only one is asserting req, grant that one.
  - Never ack both in the same cycle.
- **ptr update:** after any grant, ptr <= the requester that was not granted. With no grant, ptr holds.
- **Write register:** on each edge, D_En <= (grant && granted addr != 0); D <= granted data; D_Addr <= granted addr.
  - With no grant, D_En <= 0. D and D_Addr hold their values.
- **Writes to R0:** still acked, so the requester completes its transfer, but D_En stays 0.
- **Scoreboard:** a 2^AW-bit busy vector.
  - Set: on an edge with rsv_en=1 and rsv_addr != 0, set busy[rsv_addr].
  - Clear: on an edge with D_En=1, clear busy[D_Addr]. This is the same edge on which the register file captures the data.
  - Set and clear on the same address at the same edge: set wins, because a newer reservation supersedes the old one.
  - A write to an unreserved register is legal; the clear is a no-op.
- **Busy outputs:** s_busy = busy[s_addr]; t_busy = busy[t_addr]. Both are forced to 0 for address 0.
- **Reset (asynchronous, any time):** D=0, D_En=0, D_Addr=0, ptr=0, busy=0. a_ack and b_ack are forced to 0 while reset is high.
  - A transfer in flight at reset is dropped.
  - Requesters re-present their request after reset releases.

## Timing
- **Accept to write:** request accepted at edge N; D_En=1 during cycle N+1; register file written at edge N+1.
  - New data is readable from the file, and busy is cleared, from cycle N+2.
- **Throughput:** one write per cycle through the shared port. With both requesters saturating, the port alternates A, B, A, B.
- **Worst-case wait:** one cycle for a requester holding req, under round-robin.
- **Ack path:** a_ack and b_ack are combinational from a_req, b_req, ptr and reset. No dependency on the data path.
- **Busy path:** s_busy and t_busy are combinational from s_addr, t_addr and the busy register. They reflect edges up to and including the most recent one.
- **Cycle after reset release:**
  - ptr=0: A wins a simultaneous request.
  - D_En=0 until the first grant.

## Test plan
- **Reset state:** assert reset mid-stream while A is requesting. Required: D_En=0, D=0, D_Addr=0, a_ack=0, s_busy=t_busy=0 during and immediately after reset.
- **Round-robin contention:** after reset, A and B both hold req for 4 cycles (A: addr 3, 0x11111111; B: addr 7, 0x22222222).
  - Required grant order: A, B, A, B.
  - Required: D_Addr sequence 3, 7, 3, 7 one cycle behind; exactly one ack high per cycle.
- **Single requester:** B alone with addr 9 / 0xDEADBEEF for 1 cycle, ptr=0. Required: b_ack=1 that cycle; next cycle D_En=1, D_Addr=9, D=0xDEADBEEF; then ptr=0.
- **R0 write:** A writes addr 0, data 0xFFFFFFFF. Required: a_ack=1 and D_En=0 in the following cycle; ptr still toggles to 1.
- **Scoreboard lifecycle:** rsv_en with addr 5, then s_addr=5; A writes addr 5 at edge N.
  - Required: s_busy=1 from the cycle after the reserve through cycle N+1; s_busy=0 from cycle N+2.
  - Required: rsv_addr=0 never sets busy.
- **Set/clear collision:** busy[5]=1; reserve addr 5 at the same edge D_En=1 with D_Addr=5. Required: busy[5] remains 1 afterward.
